ram_pkt_ctrl: RTL and testbench
===============================

Name: ram_pkt_ctrl

Overview:
- Packet sequencer for the RAM system.
- On each go request it pulses start to the incremental data generator and writes the 64 generated words into a simple dual-port RAM at addresses 0..63.
- It then reads the packet back in address order and presents the readback stream with a valid strobe.
- Sits between the top-level command source, data_generator and the RAM.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 6, RAM address width.
- PKT_LEN, 64, words per packet; must be at most 2**ADDR_W.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_go  input  1  request one packet write+readback; sampled only in IDLE.
- o_gen_start  output  1  one-cycle start pulse to the generator.
- i_gen_valid  input  1  generator data valid.
- i_gen_data  input  DATA_W  generator data.
- o_ram_wr_en  output  1  RAM write enable.
- o_ram_wr_addr  output  ADDR_W  RAM write address.
- o_ram_wr_data  output  DATA_W  RAM write data.
- o_ram_rd_en  output  1  RAM read enable; RAM returns data 1 cycle later.
- o_ram_rd_addr  output  ADDR_W  RAM read address.
- i_ram_rd_data  input  DATA_W  RAM read data.
- o_rd_valid  output  1  readback word valid.
- o_rd_data  output  DATA_W  readback word.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when the packet is complete.
- o_pkt_cnt  output  8  completed packets; wraps from 255 to 0.
- o_err  output  1  sticky readback mismatch (see Optional Feature).
- o_err_cnt  output  8  mismatch count, saturating at 255.

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; write and read counters 0. Reset in any state aborts the packet immediately, with no done pulse and no further RAM strobes.
- FSM states: IDLE, START, WRITE, READ, DRAIN, DONE.
- IDLE:
  - i_go=1 moves to START.
  - i_go is ignored in every other state; no queuing.
- START:
  - o_gen_start=1 for exactly this cycle.
  - Next state is WRITE.
- WRITE:
  - Each cycle with i_gen_valid=1, register one RAM write on the following cycle: o_ram_wr_en=1, o_ram_wr_addr=wr_cnt, o_ram_wr_data=i_gen_data.
  - wr_cnt then increments.
  - i_gen_valid=0 cycles are gaps: no write, no counter change.
  - The valid accepted with wr_cnt==PKT_LEN-1 moves the FSM to READ. wr_cnt is cleared.
  - Extra i_gen_valid beats outside WRITE are dropped, with no RAM write.
- READ:
  - For PKT_LEN consecutive cycles, o_ram_rd_en=1 and o_ram_rd_addr=rd_cnt = 0..PKT_LEN-1.
  - After issuing address PKT_LEN-1, move to DRAIN.
  - The last registered write lands in the first READ cycle at a different address; no collision handling is needed.
- Readback pipe:
  - o_rd_valid and o_rd_data are the RAM read-enable delayed by one cycle, with o_rd_data = i_ram_rd_data.
  - Readback latency is rd_en to rd_valid = 1 cycle.
- DRAIN:
  - One cycle, in which the last word's o_rd_valid is asserted.
  - Next state is DONE.
- DONE:
  - o_done=1 for one cycle and o_pkt_cnt increments.
  - Next state is IDLE.
- Counter widths:
  - wr_cnt and rd_cnt are ADDR_W+1 bits, so the comparison against PKT_LEN-1 works for PKT_LEN=2**ADDR_W.
  - Addresses are the low ADDR_W bits.
- Total latency with a gapless generator: go to done = 1 (START) + 1 (generator register) + 64 (WRITE) + 64 (READ) + 1 (DRAIN) + 1 (DONE) cycles.

Optional Feature:
- Macro: RAM_PKT_CHECK_EN.
- Defined:
  - The first word written in each packet is captured as base.
  - Each readback word i is compared against base+i, modulo 2**DATA_W.
  - On a mismatch in the cycle where o_rd_valid=1, the next cycle sets o_err=1, which is sticky until i_rst, and increments o_err_cnt, saturating at 255.
- Not defined: o_err and o_err_cnt are tied to 0, and no compare logic is synthesized.

Test Plan:
- Reset, then a single i_go with a real data_generator and RAM:
  - o_gen_start pulses once.
  - Writes go to addresses 0..63 with data 1..64.
  - Readback gives data 1..64 in order.
  - o_done pulses once; o_pkt_cnt=1; o_err=0.
- Second i_go after done:
  - Writes and readback carry data 65..128.
  - o_pkt_cnt=2; checker base=65; no error.
- Generator model inserts a 3-cycle gap after word 10:
  - No write during the gap.
  - Addresses remain contiguous 0..63.
  - Done arrives 3 cycles later than the gapless case.
- i_go held high for the whole packet:
  - Only one packet runs; o_gen_start pulses once.
  - A new START occurs only in the cycle after returning to IDLE.
- i_rst asserted in READ with rd_cnt=20:
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - No o_done; o_pkt_cnt is unchanged.
- RAM_PKT_CHECK_EN, RAM model corrupting address 5:
  - o_err rises one cycle after the sixth o_rd_valid.
  - o_err_cnt=1 and stays so through done.

Source files
------------

// File: rtl/ram_pkt_ctrl.sv
// ram_pkt_ctrl: packet sequencer for the RAM system.
//
// Each go request pulses the data generator, writes PKT_LEN generated words
// into a simple dual-port RAM at addresses 0..PKT_LEN-1, then reads the packet
// back in address order and presents it with a valid strobe.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_go                  start one packet (sampled only in IDLE)
//   o_gen_start           one-cycle start pulse to the generator
//   i_gen_valid/_data     generator output stream
//   o_ram_wr_*            registered RAM write port
//   o_ram_rd_en/_addr     RAM read port (RAM answers one cycle later)
//   i_ram_rd_data         RAM read data
//   o_rd_valid/_data      readback stream
//   o_busy, o_done        status; done pulses once per completed packet
//   o_pkt_cnt             completed packets (wraps)
//   o_err, o_err_cnt      readback check result
//
// Optional: define RAM_PKT_CHECK_EN to compare each readback word against
// base+i, where base is the first word written in the packet. Without it
// o_err/o_err_cnt are tied to 0.

module ram_pkt_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 6,
    parameter int PKT_LEN = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_go,
    output logic              o_gen_start,
    input  logic              i_gen_valid,
    input  logic [DATA_W-1:0] i_gen_data,
    output logic              o_ram_wr_en,
    output logic [ADDR_W-1:0] o_ram_wr_addr,
    output logic [DATA_W-1:0] o_ram_wr_data,
    output logic              o_ram_rd_en,
    output logic [ADDR_W-1:0] o_ram_rd_addr,
    input  logic [DATA_W-1:0] i_ram_rd_data,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [7:0]        o_pkt_cnt,
    output logic              o_err,
    output logic [7:0]        o_err_cnt
);

    // One extra counter bit so PKT_LEN == 2**ADDR_W still compares cleanly.
    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PKT_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_vld_q, rd_vld_d;
    logic [7:0]        pkt_cnt_q, pkt_cnt_d;
    logic              wr_acc;
    logic              rd_en;

    // Generator beats are only accepted in WRITE; stray beats are dropped.
    assign wr_acc = (state_q == S_WRITE) && i_gen_valid;
    assign rd_en  = (state_q == S_READ);

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        pkt_cnt_d = pkt_cnt_q;
        wr_en_d   = wr_acc;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_vld_d  = rd_en;

        if (wr_acc) begin
            wr_addr_d = wr_cnt_q[ADDR_W-1:0];
            wr_data_d = i_gen_data;
        end

        case (state_q)
            S_IDLE: begin
                if (i_go) state_d = S_START;
            end
            S_START: begin
                wr_cnt_d = '0;
                rd_cnt_d = '0;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                if (wr_acc) begin
                    if (wr_cnt_q == LAST) begin
                        wr_cnt_d = '0;
                        state_d  = S_READ;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_READ: begin
                if (rd_cnt_q == LAST) begin
                    rd_cnt_d = '0;
                    state_d  = S_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            // Last readback word is valid here.
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                pkt_cnt_d = pkt_cnt_q + 8'd1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_vld_q  <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_vld_q  <= rd_vld_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign o_gen_start   = (state_q == S_START);
    assign o_ram_wr_en   = wr_en_q;
    assign o_ram_wr_addr = wr_addr_q;
    assign o_ram_wr_data = wr_data_q;
    assign o_ram_rd_en   = rd_en;
    assign o_ram_rd_addr = rd_cnt_q[ADDR_W-1:0];
    assign o_rd_valid    = rd_vld_q;
    // Gated so the readback bus is quiet (zero) outside valid cycles.
    assign o_rd_data     = rd_vld_q ? i_ram_rd_data : '0;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE);
    assign o_pkt_cnt     = pkt_cnt_q;

`ifdef RAM_PKT_CHECK_EN
    logic [DATA_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  chk_idx_q, chk_idx_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              mismatch;

    always_comb begin
        base_d    = base_q;
        chk_idx_d = chk_idx_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;

        // First accepted word of the packet is the reference.
        if (wr_acc && (wr_cnt_q == '0)) base_d = i_gen_data;

        if (state_q == S_START)  chk_idx_d = '0;
        else if (rd_vld_q)       chk_idx_d = chk_idx_q + CNT_W'(1);

        mismatch = rd_vld_q && (i_ram_rd_data != (base_q + DATA_W'(chk_idx_q)));
        if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            base_q    <= '0;
            chk_idx_q <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            base_q    <= base_d;
            chk_idx_q <= chk_idx_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;
`else
    assign o_err     = 1'b0;
    assign o_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ram_pkt_ctrl.sv
// Directed bench for ram_pkt_ctrl with a behavioural incremental generator
// (one register of start latency, optional 3-cycle gap after word 10) and a
// 64-word RAM with one-cycle read latency (optional corruption at address 5).

module tb_ram_pkt_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_go;
    logic        o_gen_start;
    logic        i_gen_valid;
    logic [31:0] i_gen_data;
    logic        o_ram_wr_en;
    logic [5:0]  o_ram_wr_addr;
    logic [31:0] o_ram_wr_data;
    logic        o_ram_rd_en;
    logic [5:0]  o_ram_rd_addr;
    logic [31:0] i_ram_rd_data;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_pkt_cnt;
    logic        o_err;
    logic [7:0]  o_err_cnt;

    ram_pkt_ctrl #(.DATA_W(32), .ADDR_W(6), .PKT_LEN(64)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_go(i_go), .o_gen_start(o_gen_start),
        .i_gen_valid(i_gen_valid), .i_gen_data(i_gen_data),
        .o_ram_wr_en(o_ram_wr_en), .o_ram_wr_addr(o_ram_wr_addr), .o_ram_wr_data(o_ram_wr_data),
        .o_ram_rd_en(o_ram_rd_en), .o_ram_rd_addr(o_ram_rd_addr), .i_ram_rd_data(i_ram_rd_data),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_busy(o_busy), .o_done(o_done),
        .o_pkt_cnt(o_pkt_cnt), .o_err(o_err), .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_pass = 0;
    int n_total = 0;

    // ---------------- generator model ----------------
    logic        st_q = 1'b0;
    logic        gen_valid = 1'b0;
    logic [31:0] gen_data = '0;
    logic [31:0] nv = 32'd1;
    int          rem = 0;
    int          emitted = 0;
    int          gap_ctr = 0;
    logic        gap_en = 1'b0;
    logic        extra_vld = 1'b0;

    assign i_gen_valid = gen_valid | extra_vld;
    assign i_gen_data  = gen_data;

    always @(posedge i_clk) begin
        gen_valid <= 1'b0;
        if (i_rst) begin
            st_q <= 1'b0; nv <= 32'd1; rem <= 0; gap_ctr <= 0; emitted <= 0;
        end else begin
            st_q <= o_gen_start;
            if (st_q) begin
                gen_valid <= 1'b1; gen_data <= nv; nv <= nv + 32'd1;
                rem <= 63; emitted <= 1; gap_ctr <= 0;
            end else if (rem != 0 && gap_ctr != 0) begin
                gap_ctr <= gap_ctr - 1;
            end else if (rem != 0) begin
                gen_valid <= 1'b1; gen_data <= nv; nv <= nv + 32'd1;
                rem <= rem - 1; emitted <= emitted + 1;
                if (gap_en && emitted == 9) gap_ctr <= 3;
            end
        end
    end

    // ---------------- RAM model ----------------
    logic [31:0] mem [64];
    logic [31:0] ram_rd = '0;
    logic        corrupt = 1'b0;
    assign i_ram_rd_data = ram_rd;

    always @(posedge i_clk) begin
        if (o_ram_wr_en) mem[o_ram_wr_addr] <= o_ram_wr_data;
        if (o_ram_rd_en)
            ram_rd <= mem[o_ram_rd_addr] ^ ((corrupt && o_ram_rd_addr == 6'd5) ? 32'h1 : 32'h0);
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          start_cnt = 0, start_cyc = 0;
    int          done_cnt = 0, done_cyc = 0;
    int          err_rise = -1;
    logic        prev_err = 1'b0;
    int          wr_a[$];
    logic [31:0] wr_d[$];
    logic [31:0] rd_d[$];
    int          rd_c[$];

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        prev_err <= o_err;
        if (o_gen_start) begin start_cnt <= start_cnt + 1; start_cyc <= cyc; end
        if (o_done)      begin done_cnt <= done_cnt + 1;   done_cyc <= cyc;  end
        if (o_ram_wr_en) begin wr_a.push_back(int'(o_ram_wr_addr)); wr_d.push_back(o_ram_wr_data); end
        if (o_rd_valid)  begin rd_d.push_back(o_rd_data); rd_c.push_back(cyc); end
        if (o_err && !prev_err && err_rise < 0) err_rise <= cyc;
    end

    int exp_base;
    int exp_pkts;

    function automatic int wr_errs(input int base);
        int e = 0;
        if (wr_a.size() != 64) return 1000 + wr_a.size();
        for (int i = 0; i < 64; i++)
            if (wr_a[i] != i || wr_d[i] !== 32'(base + i)) e++;
        return e;
    endfunction

    function automatic int rd_errs(input int base);
        int e = 0;
        if (rd_d.size() != 64) return 1000 + rd_d.size();
        for (int i = 0; i < 64; i++)
            if (rd_d[i] !== 32'(base + i)) e++;
        return e;
    endfunction

    task automatic clear_q();
        wr_a.delete(); wr_d.delete(); rd_d.delete(); rd_c.delete();
    endtask

    task automatic reset_dut();
        @(negedge i_clk); i_rst = 1'b1;
        @(negedge i_clk); @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // Launch one go and wait (bounded) for done. lat = done cycle - go cycle.
    task automatic run_pkt(input bit hold_go, output int lat, output bit to);
        int d0 = done_cnt;
        int go_cyc;
        clear_q();
        i_go = 1'b1; go_cyc = cyc;
        @(negedge i_clk);
        if (!hold_go) i_go = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (done_cnt != d0) begin to = 1'b0; break; end
            @(negedge i_clk);
        end
        lat = done_cyc - go_cyc;
    endtask

    task automatic test_reset();
        n_total++;
        if ({o_gen_start, o_ram_wr_en, o_ram_rd_en, o_rd_valid, o_busy, o_done} !== 6'b0) begin
            $display("FAIL reset_strobes got=%b want=000000",
                     {o_gen_start, o_ram_wr_en, o_ram_rd_en, o_rd_valid, o_busy, o_done});
        end else n_pass++;
        n_total++;
        if ({o_ram_wr_addr, o_ram_rd_addr} !== 12'd0 || o_ram_wr_data !== 32'd0 || o_rd_data !== 32'd0) begin
            $display("FAIL reset_buses got wa=%0d ra=%0d wd=%h rd=%h want all 0",
                     o_ram_wr_addr, o_ram_rd_addr, o_ram_wr_data, o_rd_data);
        end else n_pass++;
        n_total++;
        if (o_pkt_cnt !== 8'd0 || o_err !== 1'b0 || o_err_cnt !== 8'd0) begin
            $display("FAIL reset_counts got pkt=%0d err=%b errcnt=%0d want 0/0/0", o_pkt_cnt, o_err, o_err_cnt);
        end else n_pass++;
    endtask

    task automatic test_abort_in_read();
        int d0 = done_cnt;
        int nw, nr;
        bit hit = 1'b0;
        i_go = 1'b1;
        @(negedge i_clk); i_go = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (o_ram_rd_en && o_ram_rd_addr == 6'd20) begin hit = 1'b1; break; end
            @(negedge i_clk);
        end
        n_total++;
        if (!hit) $display("FAIL abort_reach_rd20 got=timeout want=rd_addr 20");
        else n_pass++;
        i_rst = 1'b1;
        @(negedge i_clk);
        n_total++;
        if ({o_gen_start, o_ram_wr_en, o_ram_rd_en, o_rd_valid, o_busy, o_done} !== 6'b0 ||
            o_ram_rd_addr !== 6'd0 || o_rd_data !== 32'd0 || o_pkt_cnt !== 8'd0) begin
            $display("FAIL abort_outputs got strobes=%b ra=%0d rd=%h pkt=%0d want all 0",
                     {o_gen_start, o_ram_wr_en, o_ram_rd_en, o_rd_valid, o_busy, o_done},
                     o_ram_rd_addr, o_rd_data, o_pkt_cnt);
        end else n_pass++;
        i_rst = 1'b0;
        @(negedge i_clk);
        nw = wr_a.size(); nr = rd_d.size();
        repeat (6) @(negedge i_clk);
        n_total++;
        if (done_cnt != d0 || o_pkt_cnt !== 8'd0) begin
            $display("FAIL abort_no_done got dones=%0d pkt=%0d want 0/0", done_cnt - d0, o_pkt_cnt);
        end else n_pass++;
        n_total++;
        if (wr_a.size() != nw || rd_d.size() != nr || o_busy !== 1'b0) begin
            $display("FAIL abort_quiet got wr=%0d rd=%0d busy=%b want 0/0/0",
                     wr_a.size() - nw, rd_d.size() - nr, o_busy);
        end else n_pass++;
    endtask

    task automatic test_single();
        int s0 = start_cnt;
        int lat; bit to;
        run_pkt(1'b0, lat, to);
        n_total++;
        if (to) $display("FAIL single_done_timeout got=timeout want=done");
        else n_pass++;
        n_total++;
        if (start_cnt - s0 != 1) $display("FAIL single_start_pulses got=%0d want=1", start_cnt - s0);
        else n_pass++;
        n_total++;
        if (wr_errs(exp_base) != 0) $display("FAIL single_writes got bad=%0d want=0", wr_errs(exp_base));
        else n_pass++;
        n_total++;
        if (rd_errs(exp_base) != 0) $display("FAIL single_readback got bad=%0d want=0", rd_errs(exp_base));
        else n_pass++;
        n_total++;
        if (lat != 132) $display("FAIL single_latency got=%0d want=132", lat);
        else n_pass++;
        exp_pkts++;
        n_total++;
        if (o_pkt_cnt !== 8'(exp_pkts) || o_err !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL single_status got pkt=%0d err=%b busy=%b want %0d/0/0", o_pkt_cnt, o_err, o_busy, exp_pkts);
        else n_pass++;
        exp_base += 64;
    endtask

    task automatic test_second();
        int lat; bit to;
        run_pkt(1'b0, lat, to);
        n_total++;
        if (to || wr_errs(exp_base) != 0 || rd_errs(exp_base) != 0)
            $display("FAIL second_stream got to=%b wbad=%0d rbad=%0d want 0/0/0", to, wr_errs(exp_base), rd_errs(exp_base));
        else n_pass++;
        exp_pkts++;
        n_total++;
        if (o_pkt_cnt !== 8'(exp_pkts) || o_err !== 1'b0 || o_err_cnt !== 8'd0)
            $display("FAIL second_status got pkt=%0d err=%b ecnt=%0d want %0d/0/0", o_pkt_cnt, o_err, o_err_cnt, exp_pkts);
        else n_pass++;
        exp_base += 64;
    endtask

    task automatic test_extra_valid();
        clear_q();
        extra_vld = 1'b1;
        repeat (3) @(negedge i_clk);
        extra_vld = 1'b0;
        repeat (2) @(negedge i_clk);
        n_total++;
        if (wr_a.size() != 0 || o_busy !== 1'b0)
            $display("FAIL idle_valid_dropped got writes=%0d busy=%b want 0/0", wr_a.size(), o_busy);
        else n_pass++;
    endtask

    task automatic test_gap();
        int lat; bit to;
        gap_en = 1'b1;
        run_pkt(1'b0, lat, to);
        gap_en = 1'b0;
        n_total++;
        if (to || wr_errs(exp_base) != 0)
            $display("FAIL gap_writes got to=%b bad=%0d want 0/0", to, wr_errs(exp_base));
        else n_pass++;
        n_total++;
        if (rd_errs(exp_base) != 0) $display("FAIL gap_readback got bad=%0d want=0", rd_errs(exp_base));
        else n_pass++;
        n_total++;
        if (lat != 135) $display("FAIL gap_latency got=%0d want=135", lat);
        else n_pass++;
        exp_pkts++;
        exp_base += 64;
    endtask

    task automatic test_go_held();
        int s0 = start_cnt;
        int lat; bit to;
        int d1;
        bit seen = 1'b0;
        run_pkt(1'b1, lat, to);
        n_total++;
        if (to || start_cnt - s0 != 1 || wr_errs(exp_base) != 0)
            $display("FAIL held_one_packet got to=%b starts=%0d wbad=%0d want 0/1/0", to, start_cnt - s0, wr_errs(exp_base));
        else n_pass++;
        exp_pkts++;
        exp_base += 64;
        d1 = done_cyc;
        for (int k = 0; k < 10; k++) begin
            if (start_cnt - s0 == 2) begin seen = 1'b1; break; end
            @(negedge i_clk);
        end
        i_go = 1'b0;
        n_total++;
        if (!seen || start_cyc != d1 + 2)
            $display("FAIL held_restart got seen=%b cyc=%0d want cyc=%0d", seen, start_cyc - d1, 2);
        else n_pass++;
        clear_q();
        for (int k = 0; k < 400; k++) begin
            if (!o_busy) break;
            @(negedge i_clk);
        end
        exp_pkts++;
        exp_base += 64;
        n_total++;
        if (o_busy !== 1'b0 || o_pkt_cnt !== 8'(exp_pkts) || start_cnt - s0 != 2)
            $display("FAIL held_finish got busy=%b pkt=%0d starts=%0d want 0/%0d/2", o_busy, o_pkt_cnt, start_cnt - s0, exp_pkts);
        else n_pass++;
    endtask

`ifdef RAM_PKT_CHECK_EN
    task automatic test_check_err();
        int lat; bit to;
        corrupt = 1'b1;
        run_pkt(1'b0, lat, to);
        corrupt = 1'b0;
        n_total++;
        if (to || rd_c.size() < 6 || err_rise != rd_c[5] + 1)
            $display("FAIL err_rise got to=%b rise=%0d sixth_valid=%0d want rise=sixth+1",
                     to, err_rise, (rd_c.size() > 5) ? rd_c[5] : -1);
        else n_pass++;
        n_total++;
        if (o_err !== 1'b1 || o_err_cnt !== 8'd1)
            $display("FAIL err_count got err=%b cnt=%0d want 1/1", o_err, o_err_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        i_rst = 1'b1; i_go = 1'b0;
        exp_base = 1; exp_pkts = 0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        test_reset();
        test_abort_in_read();
        reset_dut();
        test_single();
        test_second();
        test_extra_valid();
        test_gap();
        test_go_held();
`ifdef RAM_PKT_CHECK_EN
        test_check_err();
`else
        n_total++;
        if (o_err !== 1'b0 || o_err_cnt !== 8'd0)
            $display("FAIL err_tied got err=%b cnt=%0d want 0/0", o_err, o_err_cnt);
        else n_pass++;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
